st_packer_8to32: RTL

- Avalon-ST symbol packer directly downstream of the 8-bit data format adapter.
- Gathers consecutive 8-bit symbols into 32-bit beats. Preserves startofpacket/endofpacket.
- On a short final beat, reports the unused byte lanes on out_empty.
- Feeds the 32-bit DMA/FIFO stage of the Mandelbrot video path.

---
 rtl/st_pkg.sv | 19 +
 rtl/st_out_reg.sv | 46 ++++
 rtl/st_packer_8to32.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/st_pkg.sv
// rtl/st_pkg.sv - shared types, constants and lane helper for the 8-to-32 symbol packer
package st_pkg;

  localparam int ST_SYMBOL_W = 8;
  localparam int ST_SYMBOLS  = 4;
  localparam int ST_EMPTY_W  = 2;

  // Framing state: outside a packet or between its sop and eop
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    INPKT = 1'b1
  } st_state_e;

  // Bit offset of the LSB of a lane; lane 0 sits in the MSBs of the beat
  function automatic int lane_lsb(input int lane, input int symbol_w, input int symbols);
    return symbol_w * (symbols - 1 - lane);
  endfunction

endpackage

// File: rtl/st_out_reg.sv
// rtl/st_out_reg.sv - single-entry registered output stage with ready/valid handshake
module st_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         space_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // The slot can take a new entry when empty or when it drains this cycle
  assign space_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // A load replaces the entry (even while draining); a drain without load empties it
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry state, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/st_packer_8to32.sv
// rtl/st_packer_8to32.sv - packs 8-bit stream symbols into 32-bit beats (optional ST_PACKER_PROTOCOL_CHECK_EN)
module st_packer_8to32
  import st_pkg::*;
#(
  parameter int SYMBOL_W = ST_SYMBOL_W,
  parameter int SYMBOLS  = ST_SYMBOLS,
  parameter int EMPTY_W  = ST_EMPTY_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic                          in_ready,
  input  logic                          in_valid,
  input  logic [SYMBOL_W-1:0]           in_data,
  input  logic                          in_startofpacket,
  input  logic                          in_endofpacket,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [SYMBOL_W*SYMBOLS-1:0]   out_data,
  output logic                          out_startofpacket,
  output logic                          out_endofpacket,
  output logic [EMPTY_W-1:0]            out_empty
`ifdef ST_PACKER_PROTOCOL_CHECK_EN
  ,
  output logic                          out_error
`endif
);

  localparam int W  = SYMBOL_W * SYMBOLS;
  localparam int AW = SYMBOL_W * (SYMBOLS - 1);
  localparam logic [EMPTY_W-1:0] LAST = EMPTY_W'(SYMBOLS - 1);
`ifdef ST_PACKER_PROTOCOL_CHECK_EN
  localparam int PW = W + 3 + EMPTY_W;
`else
  localparam int PW = W + 2 + EMPTY_W;
`endif

  logic [AW-1:0]       acc_q, acc_d;
  logic [EMPTY_W-1:0]  cnt_q, cnt_d;
  logic                sop_q, sop_d;
  st_state_e           state_q, state_d;

  logic                space;
  logic                accept;
  logic                sym_v;
  logic [SYMBOL_W-1:0] sym_data;
  logic                sym_sop;
  logic                sym_eop;
  logic                flush;
  logic [W-1:0]        merged;

  logic                load;
  logic [W-1:0]        ld_data;
  logic                ld_sop;
  logic                ld_eop;
  logic [EMPTY_W-1:0]  ld_empty;
  logic [PW-1:0]       ld_payload;
  logic [PW-1:0]       out_payload;

  assign accept = in_valid && in_ready;

  // Accumulated lanes plus the current symbol dropped into lane cnt; lanes past cnt are still zero
  assign merged = {acc_q, {SYMBOL_W{1'b0}}}
                | (W'(sym_data) << lane_lsb(int'(cnt_q), SYMBOL_W, SYMBOLS));

`ifdef ST_PACKER_PROTOCOL_CHECK_EN
  // A sop arriving mid-packet is parked here for one cycle while the partial beat is flushed
  logic                pend_q, pend_d;
  logic [SYMBOL_W-1:0] pdata_q, pdata_d;
  logic                peop_q, peop_d;
  logic                err_q, err_d;
  logic                viol;
  logic                ld_err;

  assign in_ready = space && !pend_q;
  assign sym_v    = accept || (pend_q && space);
  assign sym_data = pend_q ? pdata_q : in_data;
  assign sym_sop  = pend_q ? 1'b1 : in_startofpacket;
  assign sym_eop  = pend_q ? peop_q : in_endofpacket;
  assign viol     = accept && (in_startofpacket ? (state_q == INPKT) : (state_q == IDLE));
  assign flush    = accept && in_startofpacket && (state_q == INPKT) && (cnt_q != '0);
  assign ld_err   = flush || err_q || viol;

  // Park the violating sop symbol and track violations belonging to the beat being built
  always_comb begin
    pend_d  = pend_q;
    pdata_d = pdata_q;
    peop_d  = peop_q;
    err_d   = load ? 1'b0 : (err_q || viol);
    if (flush) begin
      pend_d  = 1'b1;
      pdata_d = in_data;
      peop_d  = in_endofpacket;
    end else if (pend_q && space) begin
      pend_d  = 1'b0;
    end
  end

  // Protocol-check state, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= 1'b0;
      pdata_q <= '0;
      peop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pdata_q <= pdata_d;
      peop_q  <= peop_d;
      err_q   <= err_d;
    end
  end

  assign ld_payload = {ld_err, ld_empty, ld_eop, ld_sop, ld_data};
  assign {out_error, out_empty, out_endofpacket, out_startofpacket, out_data} = out_payload;
`else
  assign in_ready   = space;
  assign sym_v      = accept;
  assign sym_data   = in_data;
  assign sym_sop    = in_startofpacket;
  assign sym_eop    = in_endofpacket;
  assign flush      = 1'b0;
  assign ld_payload = {ld_empty, ld_eop, ld_sop, ld_data};
  assign {out_empty, out_endofpacket, out_startofpacket, out_data} = out_payload;
`endif

  // Packing: fill lanes until the beat is full or eop closes it, then hand the beat to the output stage
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    load     = 1'b0;
    ld_data  = merged;
    ld_sop   = (cnt_q == '0) ? sym_sop : sop_q;
    ld_eop   = sym_eop;
    ld_empty = sym_eop ? (LAST - cnt_q) : '0;
    if (flush) begin
      load     = 1'b1;
      ld_data  = {acc_q, {SYMBOL_W{1'b0}}};
      ld_sop   = sop_q;
      ld_eop   = 1'b1;
      ld_empty = LAST - cnt_q + EMPTY_W'(1);
      acc_d    = '0;
      cnt_d    = '0;
      sop_d    = 1'b0;
    end else if (sym_v) begin
      if ((cnt_q == LAST) || sym_eop) begin
        load  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
        sop_d = 1'b0;
      end else begin
        acc_d = merged[W-1 -: AW];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          sop_d = sym_sop;
        end
      end
    end
  end

  // Framing tracker; observes accepted sop/eop only and never blocks data
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (in_endofpacket) begin
        state_d = IDLE;
      end else if (in_startofpacket) begin
        state_d = INPKT;
      end
    end
  end

  // Accumulator, lane count, sop flag and framing state, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      sop_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      state_q <= state_d;
    end
  end

  st_out_reg #(
    .W (PW)
  ) u_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .data_i  (ld_payload),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_payload),
    .space_o (space)
  );

endmodule
